// File: rtl/constants_reloj.sv
// Shared constants for the alarm-clock front panel and a priority helper
// used by the button event arbiter.
package constants_reloj;

  localparam int DIV_TICK_DEF    = 75000;
  localparam int N_BTN_DEF       = 4;
  localparam int ID_W_DEF        = 2;
  localparam int N_ESTABLE_DEF   = 4;
  localparam int REP_INICIO_DEF  = 400;
  localparam int REP_PERIODO_DEF = 100;

  // Index of the lowest set bit; buttons are limited to 8, so 8 bits suffice.
  function automatic logic [2:0] lowest_set(input logic [7:0] v);
    lowest_set = '0;
    for (int i = 7; i >= 0; i--) begin
      if (v[i]) lowest_set = 3'(i);
    end
  endfunction

endpackage

// File: rtl/filtro_boton.sv
// Per-button filter: 2-flop synchronizer, tick-rate debounce and hold/repeat
// counter; emits one-cycle press/repeat strobes aligned with the state update.
module filtro_boton #(
  parameter int N_ESTABLE   = 4,
  parameter int REP_INICIO  = 400,
  parameter int REP_PERIODO = 100
) (
  input  logic reloja,
  input  logic reset,
  input  logic boton,
  input  logic hab_rep,
  input  logic tick,
  output logic estado,
  output logic set_press,
  output logic set_rep
);

  localparam int EST_W  = $clog2(N_ESTABLE + 1);
  localparam int HOLD_W = $clog2(REP_INICIO + 1);

  logic [1:0]        sync_q, sync_d;
  logic [EST_W-1:0]  est_cnt_q, est_cnt_d;
  logic              estado_q, estado_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              muestra;

  assign muestra = sync_q[1];

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latch).
    sync_d    = {sync_q[0], boton};
    est_cnt_d = est_cnt_q;
    estado_d  = estado_q;
    hold_d    = hold_q;
    set_press = 1'b0;
    set_rep   = 1'b0;

    if (tick) begin
      if (muestra != estado_q) begin
        if (est_cnt_q == EST_W'(N_ESTABLE - 1)) begin
          estado_d  = ~estado_q;
          est_cnt_d = '0;
          set_press = ~estado_q;
        end else begin
          est_cnt_d = est_cnt_q + 1'b1;
        end
      end else begin
        est_cnt_d = '0;
      end
    end

    // Reload after the first repeat so later ones fall every REP_PERIODO ticks.
    if (!(estado_q && hab_rep)) begin
      hold_d = '0;
    end else if (tick) begin
      if (hold_q == HOLD_W'(REP_INICIO - 1)) begin
        hold_d  = HOLD_W'(REP_INICIO - REP_PERIODO);
        set_rep = 1'b1;
      end else begin
        hold_d = hold_q + 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge reloja or posedge reset) begin
    if (reset) begin
      sync_q    <= '0;
      est_cnt_q <= '0;
      estado_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      sync_q    <= sync_d;
      est_cnt_q <= est_cnt_d;
      estado_q  <= estado_d;
      hold_q    <= hold_d;
    end
  end

  assign estado = estado_q;

endmodule

// File: rtl/control_botones.sv
// Button controller top: sample-tick generator, per-button filters and a
// lowest-index-first arbiter driving a registered one-cycle event bus.
module control_botones
  import constants_reloj::*;
#(
  parameter int DIV_TICK    = DIV_TICK_DEF,
  parameter int N_BTN       = N_BTN_DEF,
  parameter int N_ESTABLE   = N_ESTABLE_DEF,
  parameter int REP_INICIO  = REP_INICIO_DEF,
  parameter int REP_PERIODO = REP_PERIODO_DEF,
  parameter int ID_W        = ID_W_DEF
) (
  input  logic             reloja,
  input  logic             reset,
  input  logic [N_BTN-1:0] botones,
  input  logic [N_BTN-1:0] hab_rep,
  output logic [N_BTN-1:0] estado,
  output logic             evento_valido,
  output logic [ID_W-1:0]  evento_id,
  output logic             evento_rep,
  output logic [N_BTN-1:0] pendiente
);

  localparam int TICK_W = $clog2(DIV_TICK);

  logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
  logic              tick;
  logic [N_BTN-1:0]  set_press, set_rep;
  logic [N_BTN-1:0]  pend_q, pend_d;
  logic [N_BTN-1:0]  rep_q, rep_d;
  logic              ev_valido_q, ev_valido_d;
  logic [ID_W-1:0]   ev_id_q, ev_id_d;
  logic              ev_rep_q, ev_rep_d;
  logic [ID_W-1:0]   grant;

  assign tick = (tick_cnt_q == TICK_W'(DIV_TICK - 1));

  for (genvar i = 0; i < N_BTN; i++) begin : g_filtro
    filtro_boton #(
      .N_ESTABLE  (N_ESTABLE),
      .REP_INICIO (REP_INICIO),
      .REP_PERIODO(REP_PERIODO)
    ) u_filtro (
      .reloja   (reloja),
      .reset    (reset),
      .boton    (botones[i]),
      .hab_rep  (hab_rep[i]),
      .tick     (tick),
      .estado   (estado[i]),
      .set_press(set_press[i]),
      .set_rep  (set_rep[i])
    );
  end

  always_comb begin
    tick_cnt_d  = tick ? '0 : tick_cnt_q + 1'b1;
    grant       = ID_W'(lowest_set(8'(pend_q)));
    pend_d      = pend_q;
    rep_d       = rep_q;
    ev_valido_d = |pend_q;
    ev_id_d     = ev_id_q;
    ev_rep_d    = ev_rep_q;

    if (|pend_q) begin
      pend_d[grant] = 1'b0;
      ev_id_d       = grant;
      ev_rep_d      = rep_q[grant];
    end

    // New sets come after the grant clear so a set on the granted bit is kept.
    for (int i = 0; i < N_BTN; i++) begin
      if (set_press[i]) begin
        pend_d[i] = 1'b1;
        rep_d[i]  = 1'b0;
      end else if (set_rep[i]) begin
        pend_d[i] = 1'b1;
        rep_d[i]  = 1'b1;
      end
    end
  end

  always_ff @(posedge reloja or posedge reset) begin
    if (reset) begin
      tick_cnt_q  <= '0;
      pend_q      <= '0;
      rep_q       <= '0;
      ev_valido_q <= 1'b0;
      ev_id_q     <= '0;
      ev_rep_q    <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      pend_q      <= pend_d;
      rep_q       <= rep_d;
      ev_valido_q <= ev_valido_d;
      ev_id_q     <= ev_id_d;
      ev_rep_q    <= ev_rep_d;
    end
  end

  assign evento_valido = ev_valido_q;
  assign evento_id     = ev_id_q;
  assign evento_rep    = ev_rep_q;
  assign pendiente     = pend_q;

endmodule

// File: doc/control_botones.md
Name: control_botones

Overview:
- Shared button controller for the alarm clock front panel.
- Generates the common debounce sample tick from reloja and filters N_BTN raw push-buttons.
- Detects presses and produces auto-repeat for held buttons.
- Arbitrates all button events onto a single one-cycle event bus consumed by the time/alarm setting logic.

Parameters:
DIV_TICK, 75000, reloja cycles per sample tick (tick period)
N_BTN, 4, number of buttons (2..8)
N_ESTABLE, 4, consecutive differing samples required to flip a debounced level
REP_INICIO, 400, ticks a button must be held before the first repeat event
REP_PERIODO, 100, ticks between subsequent repeat events
ID_W, 2, width of event id, ceil(log2(N_BTN))

Ports:
reloja  in  1  FPGA system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
botones  in  N_BTN  raw button inputs, asynchronous to reloja, 1 = pressed
hab_rep  in  N_BTN  per-button auto-repeat enable, synchronous
estado  out  N_BTN  debounced button levels
evento_valido  out  1  one-cycle strobe: an event is presented
evento_id  out  ID_W  index of the button owning the event
evento_rep  out  1  1 = repeat event, 0 = initial press
pendiente  out  N_BTN  events waiting for grant (debug/status)

Behaviour:
- Reset (async, active-high): all counters, synchronizers and pending/rep flags are 0; estado, evento_valido, evento_id, evento_rep and pendiente are 0.
- Synchronizer: two-flop synchronizer on every botones bit; sampled value = sync[1].
- Tick:
  - Free-running counter 0..DIV_TICK-1.
  - tick = 1 for exactly one cycle when counter == DIV_TICK-1, then counter wraps to 0.
  - The counter does not depend on buttons.
- Debounce (per button, only on tick cycles):
  - Sample != estado: stable counter +1.
  - Sample == estado: stable counter cleared.
  - Counter reaching N_ESTABLE: estado toggles and the counter clears.
  - Non-tick cycles: no change.
- Press detect: estado 0->1 sets pend[i]=1, rep[i]=0 on the same clock edge that updates estado. Release (1->0) generates no event.
- Auto-repeat:
  - While estado[i]=1 and hab_rep[i]=1, hold counter +1 per tick.
  - On reaching REP_INICIO: set pend[i]=1, rep[i]=1, reload to REP_INICIO-REP_PERIODO so later repeats fall every REP_PERIODO ticks.
  - estado[i]=0 or hab_rep[i]=0 clears the hold counter.
- Arbiter:
  - Each cycle, if pend != 0, grant the lowest set index g.
  - Next edge: evento_valido=1, evento_id=g, evento_rep=rep[g], pend[g] cleared.
  - Otherwise evento_valido=0; evento_id and evento_rep hold their previous values.
  - Outputs are registered, so latency from pend set to evento_valido is 1 cycle.
  - At most one event per cycle; no back-pressure.
- Boundaries:
  - New set on bit g in the same cycle it is granted: the set wins and pend[g] stays 1, so the event is not lost. rep[g] takes the new value.
  - Set on an already-pending bit: merged, single event, rep takes the newest value.
  - Simultaneous presses on several buttons: served lowest-index first on consecutive cycles.
  - Starvation is impossible because pend is set at tick rate (>= DIV_TICK cycles apart) and N_BTN < DIV_TICK.
  - Glitch shorter than N_ESTABLE ticks: no estado change, no event.
  - Reset asserted mid-hold or mid-debounce: everything clears immediately; after release, a still-pressed button needs N_ESTABLE ticks and then produces a fresh press event.
  - Hold-counter width: enough for REP_INICIO, no wrap while held.

Decomposition:
- Shared package (constants_reloj): DIV_TICK default, ID_W, and default N_ESTABLE/REP_INICIO/REP_PERIODO constants used by the top-level alarm clock.
- Sub-module filtro_boton, instantiated N_BTN times: synchronizer, debounce counter, estado, hold/repeat counter. Outputs estado plus one-cycle set_press/set_rep strobes.
- Top level keeps the tick generator, pend/rep registers and priority arbiter.

Test Plan (bench params: DIV_TICK=4, N_ESTABLE=3, REP_INICIO=5, REP_PERIODO=2, N_BTN=4):
1. Reset, then botones=0000 for 100 cycles -> tick every 4th cycle, estado=0000, evento_valido never 1. Assert reset mid-run -> all outputs 0 within the same cycle.
2. botones[1] rises and stays high, hab_rep=0 -> estado[1]=1 on the 3rd tick after sync; exactly one evento_valido with id=1, rep=0 one cycle later; nothing more while held.
3. botones[2] pulses high for 2 ticks then low -> estado stays 0000, no event. Bouncing 1/0/1/1/1 per tick -> a single event after three consecutive 1s.
4. botones[0] held, hab_rep[0]=1 -> press event (id=0, rep=0), then repeat events (rep=1) at 5, 7, 9, ... ticks after estado rose. Release -> repeats stop, no release event.
5. botones[3] and botones[1] rise in the same cycle -> estado both flip on the same tick; evento_valido on two consecutive cycles, id=1 then id=3; pendiente shows 1010 then 1000 then 0000.
6. Force a repeat set on button 0 in the cycle pend[0] is being granted -> two events for id 0 on consecutive cycles, no event lost.
